// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg
//   Shared definitions for the multicycle processor main controller:
//   state enumeration with fixed state codes, instruction op field values,
//   and the select encodings for the ResultSrc and ALUSrcB muxes.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // Instruction op field
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Funct bit positions
  localparam int FUNCT_I_BIT = 5;
  localparam int FUNCT_S_BIT = 0;

endpackage

// File: rtl/main_fsm.sv
// main_fsm
//   Moore main controller for a multicycle processor. All outputs decode
//   from the registered state; Op/Funct only steer the next state.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (returns to FETCH)
//   Op        in   [1:0] instruction op field
//   Funct     in   [5:0] instruction funct field ([5]=I, [0]=S/L)
//   IRWrite   out  instruction register load enable
//   AdrSrc    out  memory address select (0=PC, 1=ALU result)
//   ALUSrcA   out  ALU operand A select
//   ALUSrcB   out  [1:0] ALU operand B select
//   ResultSrc out  [1:0] result bus select
//   NextPC    out  PC write strobe
//   RegW      out  register file write strobe
//   MemW      out  memory write strobe
//   Branch    out  branch strobe
//   ALUOp     out  0=forced ADD, 1=decode Funct
//   State     out  [3:0] current state code
//   Illegal   out  high while in UNKNOWN
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State,
  output logic       Illegal
);

  state_e state_q;
  state_e state_d;
  state_e dec_state;

  logic irwrite_raw;
  logic nextpc_raw;
  logic regw_raw;
  logic memw_raw;
  logic branch_raw;

  // Funct[4:1] is consumed by the downstream ALU decoder, not here.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_UNKNOWN;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[FUNCT_I_BIT] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[FUNCT_S_BIT] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // UNKNOWN holds, and unused codes 11-15 fall into UNKNOWN.
      default:    state_d = S_UNKNOWN;
    endcase
  end

  // While rst is high the register may not yet hold FETCH (first cycle after
  // power-up), so the decode is forced to FETCH and the write strobes are
  // suppressed to keep the datapath from committing anything during reset.
  assign dec_state = rst ? S_FETCH : state_q;

  // Output decode
  always_comb begin
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch_raw  = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ResultSrc   = RES_ALUOUT;
    ALUOp       = 1'b0;
    Illegal     = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        irwrite_raw = 1'b1;
        nextpc_raw  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regw_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUOp = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        branch_raw = 1'b1;
      end
      default: begin
        Illegal = 1'b1;
      end
    endcase
  end

  assign IRWrite = irwrite_raw & ~rst;
  assign NextPC  = nextpc_raw  & ~rst;
  assign RegW    = regw_raw    & ~rst;
  assign MemW    = memw_raw    & ~rst;
  assign Branch  = branch_raw  & ~rst;
  assign State   = dec_state;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm
//   Directed testbench for main_fsm: reset, load, store, data-processing,
//   branch, illegal op, and reset in the middle of an instruction.
module tb_main_fsm;

  logic       clk;
  logic       rst;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;
  logic       Illegal;

  int n_checks;
  int n_errors;

  main_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .State     (State),
    .Illegal   (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,Illegal,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
  logic [12:0] outs;
  assign outs = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, Illegal,
                 AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};

  // Hand-written expected output vectors per state code.
  function automatic logic [12:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd0:    return {7'b1100000, 1'b0, 1'b1, 2'b10, 2'b10};
      4'd1:    return {7'b0000000, 1'b0, 1'b1, 2'b10, 2'b10};
      4'd2:    return {7'b0000000, 1'b0, 1'b0, 2'b01, 2'b00};
      4'd3:    return {7'b0000000, 1'b1, 1'b0, 2'b00, 2'b00};
      4'd4:    return {7'b0010000, 1'b0, 1'b0, 2'b00, 2'b01};
      4'd5:    return {7'b0001000, 1'b1, 1'b0, 2'b00, 2'b00};
      4'd6:    return {7'b0000010, 1'b0, 1'b0, 2'b00, 2'b00};
      4'd7:    return {7'b0000010, 1'b0, 1'b0, 2'b01, 2'b00};
      4'd8:    return {7'b0010000, 1'b0, 1'b0, 2'b00, 2'b00};
      4'd9:    return {7'b0000100, 1'b0, 1'b0, 2'b01, 2'b10};
      default: return {7'b0000001, 1'b0, 1'b0, 2'b00, 2'b00};
    endcase
  endfunction

  // FETCH values with every write strobe held low.
  localparam logic [12:0] RESET_OUTS = {7'b0000000, 1'b0, 1'b1, 2'b10, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH; seq holds the expected state codes one
  // nibble per cycle, first cycle in the low nibble. Op and Funct are
  // scrambled once they should no longer be sampled.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] funct, input int n,
                           input logic [31:0] seq);
    logic [3:0] es;
    Op    = op;
    Funct = funct;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      if (i == 2) Op = ~op;
      if (i == 3) Funct = ~funct;
      es = seq[i*4 +: 4];
      check($sformatf("%s state c%0d", name, i), 32'(State), 32'(es));
      check($sformatf("%s outs c%0d", name, i), 32'(outs), 32'(exp_outs(es)));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    Op    = 2'b00;
    Funct = 6'b000000;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("reset state c%0d", i), 32'(State), 32'd0);
      check($sformatf("reset outs c%0d", i), 32'(outs), 32'(RESET_OUTS));
    end
    rst = 1'b0;
    #1;
    check("post-reset IRWrite", 32'(IRWrite), 32'd1);
    check("post-reset NextPC", 32'(NextPC), 32'd1);

    // Load: 0,1,2,3,4,0
    run_instr("load", 2'b01, 6'b000001, 6, 32'h043210);
    // Store: 0,1,2,5,0
    run_instr("store", 2'b01, 6'b000000, 5, 32'h05210);
    // DP immediate: 0,1,7,8,0
    run_instr("dpi", 2'b00, 6'b101000, 5, 32'h08710);
    // DP register: 0,1,6,8,0
    run_instr("dpr", 2'b00, 6'b001000, 5, 32'h08610);
    // Branch: 0,1,9,0
    run_instr("branch", 2'b10, 6'b000000, 4, 32'h0910);

    // Illegal op: 0,1,10 then held
    run_instr("illegal", 2'b11, 6'b000000, 3, 32'hA10);
    for (int i = 0; i < 20; i++) begin
      Op    = 2'(i);
      Funct = 6'(i * 7);
      step();
      check($sformatf("illegal hold state c%0d", i), 32'(State), 32'd10);
      check($sformatf("illegal hold flag c%0d", i), 32'(Illegal), 32'd1);
    end
    rst = 1'b1;
    step();
    check("illegal rst state", 32'(State), 32'd0);
    check("illegal rst outs", 32'(outs), 32'(RESET_OUTS));
    rst = 1'b0;
    #1;
    check("illegal release state", 32'(State), 32'd0);
    check("illegal release outs", 32'(outs), 32'(exp_outs(4'd0)));

    // Reset asserted while in MEMREAD
    Op    = 2'b01;
    Funct = 6'b000001;
    step();
    check("midrst decode", 32'(State), 32'd1);
    step();
    check("midrst memadr", 32'(State), 32'd2);
    step();
    check("midrst memread", 32'(State), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst RegW during rst", 32'(RegW), 32'd0);
    step();
    check("midrst state after edge", 32'(State), 32'd0);
    check("midrst RegW after edge", 32'(RegW), 32'd0);
    rst = 1'b0;
    Op  = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("midrst RegW c%0d", i), 32'(RegW), 32'd0);
      step();
    end
    check("midrst recovered state", 32'(State), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
